enigma_pipe: RTL and testbench
==============================

ENIGMA_PIPE -- requirements
Module: enigma_pipe

Interface
REQ-001 SHALL have parameter NUM_ROTORS, default 3, range 3..4, number of cascaded stepping rotors.
REQ-002 SHALL have parameter REFLECTOR, default 0, 0=UKW-B (YRUHQSLDPXNGOKMIEBFZCWVJAT), 1=UKW-C (FVPJIAOYEDRZXWGCTKUQSBNMHL).
REQ-003 SHALL have ports: clk_in  in  1  clock; rst_in  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: cfg_valid_in  in  1  load config; rotor_select  in  3*NUM_ROTORS  field k = wheel for rotor k (1..5); rotor_initial  in  5*NUM_ROTORS  start positions; ring_setting  in  5*NUM_ROTORS  ring offsets.
REQ-005 SHALL have ports: plug_we  in  1; plug_a  in  5; plug_b  in  5  plugboard pair write.
REQ-006 SHALL have ports: data_valid_in  in  1; data_in  in  5  letter 0..25 (A=0); ready  out  1; data_valid_out  out  1; data_out  out  5; rotor_pos  out  5*NUM_ROTORS  current positions.

Function
REQ-007 SHALL use rotor 0 as fastest (rightmost); field k of each bus at bits [W*k+W-1:W*k].
REQ-008 SHALL use wheel wirings I EKMFLGDQVZNTOWYHXUSPAIBRCJ, II AJDKSIRUXBLHWTMCQGZNPYFVOE, III BDFHJLCPRTXVZNYEIWGAKMUSQO, IV ESOVPZJAYQUIRHXLNFTGKBCDMW, V VZBRGITYUPSDNHLXAWMJQOFECK; notches (turnover positions) I=16, II=4, III=21, IV=9, V=25; select value outside 1..5 selects wheel I.
REQ-009 SHALL on cfg_valid_in latch wheels, positions and rings; position/ring fields >25 latched as 0; clear all pipeline valids (in-flight characters dropped); ready=0 that cycle; plugboard unchanged.
REQ-010 SHALL give cfg_valid_in priority over data_valid_in in the same cycle (character not accepted).
REQ-011 SHALL accept a character when data_valid_in && ready; ready=1 every cycle except reset and cfg cycles; one character per cycle sustained.
REQ-012 SHALL step rotors on acceptance, before encoding: rotor 0 always; rotor k>=1 steps if pos[k-1]==notch[k-1], or (k<NUM_ROTORS-1 and pos[k]==notch[k]) (double step); positions wrap 25->0; all conditions evaluated on pre-step positions.
REQ-013 SHALL encode each character with the post-step positions captured at acceptance, carried down the pipeline with the data, unaffected by later steps.
REQ-014 SHALL compute rotor forward map with off=(pos-ring) mod 26: out=(W[(x+off) mod 26]-off) mod 26; backward uses inverse wiring with same offsets; all arithmetic mod 26 on 5-bit values.
REQ-015 SHALL encode path: plugboard, rotors 0..N-1, reflector, rotors N-1..0, plugboard; one register stage per element; latency L=2*NUM_ROTORS+3 cycles from accept to data_valid_out (L=9 for N=3).
REQ-016 SHALL pass data_in 26..31 through unchanged with latency L and without stepping rotors.
REQ-017 SHALL on plug_we (plug_a,plug_b <=25) set old partners of plug_a and plug_b to self, then map plug_a<->plug_b; plug_a==plug_b clears that letter; either address >25 ignores write; new map used from next cycle, including characters in flight.
REQ-018 SHALL drive rotor_pos with registered current positions, updated the cycle after each step or cfg load.

Reset
REQ-019 SHALL on rst_in: ready=0, data_valid_out=0, data_out=0, all pipeline valids 0, plugboard identity, wheels I/II/III for rotors 2/1/0 (rotor 3 wheel IV), positions 0, rings 0, rotor_pos=0; ready=1 first cycle after reset deasserts.
REQ-020 SHALL on reset mid-stream discard all in-flight characters; no data_valid_out afterwards until new acceptance + L.

Verification
REQ-021 SHALL pass: N=3, rotor_select={1,2,3}, positions 0, rings 0, no plugs, AAAAA -> BDZGO, rotor_pos ends {0,0,5}.
REQ-022 SHALL pass double-step: start positions {A,D,U}={0,3,20}, three characters -> rotor_pos {0,3,21}, {0,4,22}, {1,5,23}.
REQ-023 SHALL pass reciprocity: encrypt 26-letter string with plugs (A,Z),(B,Y), reload cfg, encrypt ciphertext -> original string; no output letter equals its input.
REQ-024 SHALL pass throughput: 5 characters on consecutive cycles -> data_valid_out high 5 consecutive cycles starting exactly L cycles after first accept.
REQ-025 SHALL pass flush: cfg_valid_in 3 cycles after accepting 2 characters -> no data_valid_out for those; data_in=26 -> data_out=26, rotor_pos unchanged.

Source files
------------

// File: rtl/enigma_pipe.sv
// Pipelined Enigma cipher: plugboard, NUM_ROTORS stepping rotors, reflector, rotors back, plugboard.
// One register stage per element; each character carries its own rotor positions down the pipe.
module enigma_pipe #(
  parameter int NUM_ROTORS = 3,
  parameter int REFLECTOR  = 0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      cfg_valid_in,
  input  logic [3*NUM_ROTORS-1:0]   rotor_select,
  input  logic [5*NUM_ROTORS-1:0]   rotor_initial,
  input  logic [5*NUM_ROTORS-1:0]   ring_setting,
  input  logic                      plug_we,
  input  logic [4:0]                plug_a,
  input  logic [4:0]                plug_b,
  input  logic                      data_valid_in,
  input  logic [4:0]                data_in,
  output logic                      ready,
  output logic                      data_valid_out,
  output logic [4:0]                data_out,
  output logic [5*NUM_ROTORS-1:0]   rotor_pos
);

  localparam int L = 2*NUM_ROTORS + 3;

  typedef logic [4:0] letter_t;

  localparam logic [8*26-1:0] W_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [8*26-1:0] W_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [8*26-1:0] W_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [8*26-1:0] W_IV  = "ESOVPZJAYQUIRHXLNFTGKBCDMW";
  localparam logic [8*26-1:0] W_V   = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [8*26-1:0] UKW_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  localparam logic [8*26-1:0] UKW_C = "FVPJIAOYEDRZXWGCTKUQSBNMHL";
  localparam logic [8*26-1:0] UKW   = (REFLECTOR == 1) ? UKW_C : UKW_B;

  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[4:0];
  endfunction

  function automatic letter_t sub26(input letter_t a, input letter_t b);
    return add26(a, letter_t'(5'd26 - b));
  endfunction

  // Wiring strings hold ASCII capitals with the letter for index 0 in the top byte.
  function automatic letter_t pick(input logic [8*26-1:0] s, input letter_t i);
    logic [7:0] c;
    c = s[8*(25 - int'(i)) +: 8];
    return letter_t'(c - 8'd65);
  endfunction

  function automatic logic [8*26-1:0] wiring(input logic [2:0] w);
    logic [8*26-1:0] s;
    case (w)
      3'd1:    s = W_II;
      3'd2:    s = W_III;
      3'd3:    s = W_IV;
      3'd4:    s = W_V;
      default: s = W_I;
    endcase
    return s;
  endfunction

  function automatic letter_t notch(input logic [2:0] w);
    letter_t n;
    case (w)
      3'd0:    n = 5'd16;
      3'd1:    n = 5'd4;
      3'd2:    n = 5'd21;
      3'd3:    n = 5'd9;
      default: n = 5'd25;
    endcase
    return n;
  endfunction

  function automatic letter_t wheel_inv(input logic [2:0] w, input letter_t y);
    letter_t r;
    r = '0;
    for (int j = 0; j < 26; j++)
      if (pick(wiring(w), letter_t'(j)) == y) r = letter_t'(j);
    return r;
  endfunction

  function automatic letter_t rotor_fwd(input letter_t x, input logic [2:0] w,
                                        input letter_t p, input letter_t rg);
    letter_t off;
    if (x > 5'd25) return x;
    off = sub26(p, rg);
    return sub26(pick(wiring(w), add26(x, off)), off);
  endfunction

  function automatic letter_t rotor_bwd(input letter_t x, input logic [2:0] w,
                                        input letter_t p, input letter_t rg);
    letter_t off;
    if (x > 5'd25) return x;
    off = sub26(p, rg);
    return sub26(wheel_inv(w, add26(x, off)), off);
  endfunction

  function automatic letter_t reflect(input letter_t x);
    return (x > 5'd25) ? x : pick(UKW, x);
  endfunction

  // Rotor k after reset: 0=III, 1=II, 2=I, 3=IV (wheel index is wheel number minus one).
  function automatic logic [2:0] default_wheel(input int k);
    logic [2:0] w;
    case (k)
      0:       w = 3'd2;
      1:       w = 3'd1;
      2:       w = 3'd0;
      default: w = 3'd3;
    endcase
    return w;
  endfunction

  function automatic logic [2:0] sel_wheel(input logic [2:0] s);
    return (s >= 3'd1 && s <= 3'd5) ? (s - 3'd1) : 3'd0;
  endfunction

  function automatic letter_t clamp26(input letter_t v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  logic [2:0]            wheel [NUM_ROTORS];
  letter_t               ring  [NUM_ROTORS];
  letter_t               pos   [NUM_ROTORS];
  letter_t               next_pos [NUM_ROTORS];
  letter_t               plug_map [26];
  letter_t               plug_pa;
  letter_t               plug_pb;
  logic [NUM_ROTORS-1:0] step;
  logic                  accept;
  logic                  plug_ok;
  logic [L-1:0]          stg_valid;
  letter_t               stg_data [L];
  letter_t               nxt      [L];
  letter_t               stg_pos  [L-2][NUM_ROTORS];

  assign ready   = !rst_in && !cfg_valid_in;
  assign accept  = data_valid_in && ready;
  assign plug_ok = plug_we && (plug_a <= 5'd25) && (plug_b <= 5'd25);
  assign plug_pa = plug_map[plug_a];
  assign plug_pb = plug_map[plug_b];

  assign data_valid_out = stg_valid[L-1];
  assign data_out       = stg_data[L-1];

  always_comb begin
    rotor_pos = '0;
    for (int k = 0; k < NUM_ROTORS; k++) rotor_pos[5*k +: 5] = pos[k];
  end

  // Stepping decisions all look at pre-step positions; out-of-alphabet input never steps.
  always_comb begin
    step    = '0;
    step[0] = 1'b1;
    for (int k = 1; k < NUM_ROTORS; k++)
      step[k] = (pos[k-1] == notch(wheel[k-1])) ||
                ((k < NUM_ROTORS-1) && (pos[k] == notch(wheel[k])));
    for (int k = 0; k < NUM_ROTORS; k++)
      next_pos[k] = (accept && (data_in <= 5'd25) && step[k]) ? add26(pos[k], 5'd1) : pos[k];
  end

  always_comb begin
    for (int i = 0; i < L; i++) nxt[i] = '0;
    nxt[0] = (data_in > 5'd25) ? data_in : plug_map[data_in];
    for (int k = 0; k < NUM_ROTORS; k++)
      nxt[k+1] = rotor_fwd(stg_data[k], wheel[k], stg_pos[k][k], ring[k]);
    nxt[NUM_ROTORS+1] = reflect(stg_data[NUM_ROTORS]);
    for (int j = 0; j < NUM_ROTORS; j++)
      nxt[NUM_ROTORS+2+j] = rotor_bwd(stg_data[NUM_ROTORS+1+j], wheel[NUM_ROTORS-1-j],
                                      stg_pos[NUM_ROTORS+1+j][NUM_ROTORS-1-j],
                                      ring[NUM_ROTORS-1-j]);
    nxt[L-1] = (stg_data[L-2] > 5'd25) ? stg_data[L-2] : plug_map[stg_data[L-2]];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stg_valid <= '0;
      for (int i = 0; i < L; i++) stg_data[i] <= '0;
      for (int i = 0; i < 26; i++) plug_map[i] <= letter_t'(i);
      for (int k = 0; k < NUM_ROTORS; k++) begin
        wheel[k] <= default_wheel(k);
        pos[k]   <= '0;
        ring[k]  <= '0;
      end
    end else begin
      // Old partners of both letters fall back to themselves before the new pair is made.
      if (plug_ok) begin
        for (int i = 0; i < 26; i++) begin
          if (letter_t'(i) == plug_a)
            plug_map[i] <= plug_b;
          else if (letter_t'(i) == plug_b)
            plug_map[i] <= plug_a;
          else if (letter_t'(i) == plug_pa || letter_t'(i) == plug_pb)
            plug_map[i] <= letter_t'(i);
        end
      end
      if (cfg_valid_in) begin
        stg_valid <= '0;
        for (int k = 0; k < NUM_ROTORS; k++) begin
          wheel[k] <= sel_wheel(rotor_select[3*k +: 3]);
          pos[k]   <= clamp26(rotor_initial[5*k +: 5]);
          ring[k]  <= clamp26(ring_setting[5*k +: 5]);
        end
      end else begin
        stg_valid <= {stg_valid[L-2:0], accept};
        for (int k = 0; k < NUM_ROTORS; k++) pos[k] <= next_pos[k];
      end
      for (int i = 0; i < L; i++) stg_data[i] <= nxt[i];
    end
  end

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_ROTORS; k++) stg_pos[0][k] <= next_pos[k];
    for (int i = 1; i < L-2; i++)
      for (int k = 0; k < NUM_ROTORS; k++) stg_pos[i][k] <= stg_pos[i-1][k];
  end

endmodule

// File: tb/tb_enigma_pipe.sv
// Scoreboard bench for enigma_pipe: directed vectors queue expected letters, a monitor pops
// and compares them (value and arrival cycle) whenever data_valid_out is seen.
module tb_enigma_pipe;
  localparam int N = 3;
  localparam int L = 2*N + 3;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic            cfg_valid_in;
  logic [3*N-1:0]  rotor_select;
  logic [5*N-1:0]  rotor_initial;
  logic [5*N-1:0]  ring_setting;
  logic            plug_we;
  logic [4:0]      plug_a;
  logic [4:0]      plug_b;
  logic            data_valid_in;
  logic [4:0]      data_in;
  logic            ready;
  logic            data_valid_out;
  logic [4:0]      data_out;
  logic [5*N-1:0]  rotor_pos;

  enigma_pipe #(.NUM_ROTORS(N), .REFLECTOR(0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .cfg_valid_in(cfg_valid_in),
    .rotor_select(rotor_select), .rotor_initial(rotor_initial), .ring_setting(ring_setting),
    .plug_we(plug_we), .plug_a(plug_a), .plug_b(plug_b),
    .data_valid_in(data_valid_in), .data_in(data_in), .ready(ready),
    .data_valid_out(data_valid_out), .data_out(data_out), .rotor_pos(rotor_pos)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [4:0] din;
    logic [4:0] exp;
    bit         neq;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [4:0] cipher[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         outs_seen = 0;

  localparam logic [3*N-1:0] SEL_123 = {3'd1, 3'd2, 3'd3};

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every presented output must match the oldest queued expectation, L cycles late.
  always @(negedge clk_in) begin
    if (!rst_in && data_valid_out) begin
      exp_t e;
      outs_seen++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_output actual=%0d required=none", data_out);
      end else begin
        e = sb.pop_front();
        total++;
        if (e.neq) begin
          cipher.push_back(data_out);
          if (data_out === e.din || data_out > 5'd25) begin
            bad++;
            $display("[TB] FAIL self_encrypt in=%0d actual=%0d required=other_letter", e.din, data_out);
          end
        end else if (data_out !== e.exp) begin
          bad++;
          $display("[TB] FAIL out_letter in=%0d actual=%0d required=%0d", e.din, data_out, e.exp);
        end
        check_output("out_latency", cyc, e.cyc + L);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] c, input logic [4:0] exp, input bit neq, input bit push);
    exp_t e;
    data_valid_in = 1'b1;
    data_in       = c;
    if (push) begin
      e.din = c; e.exp = exp; e.neq = neq; e.cyc = cyc;
      sb.push_back(e);
    end
    tick(1);
    data_valid_in = 1'b0;
  endtask

  task automatic load_cfg(input logic [3*N-1:0] sel, input logic [5*N-1:0] init,
                          input logic [5*N-1:0] rg, input bit with_data);
    cfg_valid_in  = 1'b1;
    rotor_select  = sel;
    rotor_initial = init;
    ring_setting  = rg;
    if (with_data) begin
      data_valid_in = 1'b1;
      data_in       = 5'd0;
    end
    #1;
    check_output("cfg_ready_low", ready, 0);
    tick(1);
    cfg_valid_in  = 1'b0;
    data_valid_in = 1'b0;
    check_output("cfg_rotor_pos", rotor_pos, init);
  endtask

  task automatic plug_write(input logic [4:0] a, input logic [4:0] b);
    plug_we = 1'b1;
    plug_a  = a;
    plug_b  = b;
    tick(1);
    plug_we = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
    tick(2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] bdzgo[5];
    logic [4:0] xdzgo[5];
    logic [4:0] bdxgo[5];
    logic [4:0] ds_in[3];
    logic [5*N-1:0] ds_pos[3];
    int snap;

    bdzgo = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    xdzgo = '{5'd23, 5'd3, 5'd25, 5'd6, 5'd14};
    bdxgo = '{5'd1, 5'd3, 5'd23, 5'd6, 5'd14};
    ds_in = '{5'd7, 5'd4, 5'd11};
    ds_pos = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}};

    rst_in = 1'b1; cfg_valid_in = 1'b0; rotor_select = '0; rotor_initial = '0;
    ring_setting = '0; plug_we = 1'b0; plug_a = '0; plug_b = '0;
    data_valid_in = 1'b0; data_in = '0;
    tick(2);
    check_output("reset_ready", ready, 0);
    check_output("reset_valid_out", data_valid_out, 0);
    check_output("reset_data_out", data_out, 0);
    check_output("reset_rotor_pos", rotor_pos, 0);
    rst_in = 1'b0;
    #1;
    check_output("ready_after_reset", ready, 1);

    // Reference vector, back-to-back so arrival timing also covers throughput.
    load_cfg(SEL_123, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(5'd0, bdzgo[i], 1'b0, 1'b1);
    check_output("aaaaa_rotor_pos", rotor_pos, {5'd0, 5'd0, 5'd5});
    wait_drain();

    load_cfg(SEL_123, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(bdzgo[i], 5'd0, 1'b0, 1'b1);
    wait_drain();

    // Plugboard rewiring: final map Q<->C, B<->X; (A,30) must be ignored.
    plug_write(5'd0, 5'd16);
    plug_write(5'd1, 5'd23);
    plug_write(5'd16, 5'd2);
    plug_write(5'd3, 5'd3);
    plug_write(5'd0, 5'd30);
    load_cfg(SEL_123, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(5'd0, xdzgo[i], 1'b0, 1'b1);
    wait_drain();
    plug_write(5'd23, 5'd25);
    load_cfg(SEL_123, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(5'd0, bdxgo[i], 1'b0, 1'b1);
    wait_drain();
    plug_write(5'd16, 5'd16);
    plug_write(5'd23, 5'd23);

    load_cfg(SEL_123, {5'd0, 5'd3, 5'd20}, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(ds_in[i], 5'd0, 1'b1, 1'b1);
      check_output("double_step_pos", rotor_pos, ds_pos[i]);
    end
    wait_drain();

    // Reciprocity with plugs and non-zero rings.
    plug_write(5'd0, 5'd25);
    plug_write(5'd1, 5'd24);
    cipher.delete();
    load_cfg(SEL_123, {5'd5, 5'd10, 5'd15}, {5'd1, 5'd2, 5'd3}, 1'b0);
    for (int i = 0; i < 26; i++) apply_stimulus(5'(i), 5'd0, 1'b1, 1'b1);
    wait_drain();
    check_output("cipher_count", cipher.size(), 26);
    load_cfg(SEL_123, {5'd5, 5'd10, 5'd15}, {5'd1, 5'd2, 5'd3}, 1'b0);
    for (int i = 0; i < 26 && i < cipher.size(); i++) apply_stimulus(cipher[i], 5'(i), 1'b0, 1'b1);
    wait_drain();

    // Flush: in-flight characters dropped; same-cycle data loses to cfg.
    load_cfg(SEL_123, {5'd0, 5'd0, 5'd7}, '0, 1'b0);
    apply_stimulus(5'd4, 5'd0, 1'b0, 1'b0);
    apply_stimulus(5'd5, 5'd0, 1'b0, 1'b0);
    check_output("flush_pre_pos", rotor_pos, {5'd0, 5'd0, 5'd9});
    tick(2);
    snap = outs_seen;
    load_cfg(SEL_123, {5'd0, 5'd0, 5'd7}, '0, 1'b1);
    tick(L + 4);
    check_output("flush_no_output", outs_seen, snap);
    apply_stimulus(5'd26, 5'd26, 1'b0, 1'b1);
    wait_drain();
    check_output("passthru_rotor_pos", rotor_pos, {5'd0, 5'd0, 5'd7});

    // Reset mid-stream, then default wheels III/II/I from position 0 must give A->B.
    for (int i = 0; i < 3; i++) apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0);
    tick(2);
    rst_in = 1'b1;
    tick(1);
    check_output("midreset_ready", ready, 0);
    check_output("midreset_valid_out", data_valid_out, 0);
    check_output("midreset_data_out", data_out, 0);
    check_output("midreset_rotor_pos", rotor_pos, 0);
    snap = outs_seen;
    rst_in = 1'b0;
    #1;
    check_output("midreset_ready_after", ready, 1);
    tick(L + 4);
    check_output("midreset_no_output", outs_seen, snap);
    apply_stimulus(5'd0, 5'd1, 1'b0, 1'b1);
    wait_drain();
    check_output("default_wheels_pos", rotor_pos, {5'd0, 5'd0, 5'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
